// File: rtl/conv_21_acc_sat.sv
// Windowed product accumulator: sums TAPS signed products plus a bias, rounds, shifts and saturates.
// Optional ReLU clamp on the result is enabled by defining CONV_21_ACC_RELU_EN.
module conv_21_acc_sat #(
  parameter int PROD_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int TAPS       = 9,
  parameter int SHIFT      = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0]  out_dout,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int TW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic [TW-1:0] LAST = TW'(TAPS - 1);
  localparam logic signed [AW1-1:0] MAXV =
    {{(AW1-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW1-1:0] MINV =
    {{(AW1-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t                      state, state_nx;
  logic [TW-1:0]               tap, tap_nx;
  logic signed [ACC_WIDTH-1:0] acc, acc_nx, acc_sum, base, prod_sx;
  logic signed [AW1-1:0]       sum_rnd, r;
  logic [OUT_WIDTH-1:0]        res, dout_nx;
  logic                        valid_nx, accept, last;

  assign prod_ready = (state == ACC) | out_ready;
  assign accept     = prod_valid & prod_ready & ~ap_rst;
  assign last       = (tap == LAST);

  always_comb begin
    prod_sx = {{(ACC_WIDTH-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
    base    = (tap == '0) ? $signed(bias) : acc;
    acc_sum = base + prod_sx;
    // Round half up in one extra bit so the rounding constant cannot overflow.
    sum_rnd = {acc_sum[ACC_WIDTH-1], acc_sum} + (AW1'(1) << (SHIFT - 1));
    r       = sum_rnd >>> SHIFT;
    if (r > MAXV)
      res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (r < MINV)
      res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      res = r[OUT_WIDTH-1:0];
`ifdef CONV_21_ACC_RELU_EN
    if (res[OUT_WIDTH-1])
      res = '0;
`endif
  end

  always_comb begin
    state_nx = state;
    tap_nx   = tap;
    acc_nx   = acc;
    dout_nx  = out_dout;
    valid_nx = out_valid;
    if (out_valid & out_ready)
      valid_nx = 1'b0;
    if (accept) begin
      acc_nx = acc_sum;
      tap_nx = last ? '0 : tap + TW'(1);
      if (last) begin
        dout_nx  = res;
        valid_nx = 1'b1;
      end
    end
    case (state)
      ACC:     if (accept & last) state_nx = HOLD;
      HOLD:    if (out_ready & ~(accept & last)) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ACC;
      tap       <= '0;
      acc       <= '0;
      out_dout  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      tap       <= tap_nx;
      acc       <= acc_nx;
      out_dout  <= dout_nx;
      out_valid <= valid_nx;
    end
  end

endmodule

// File: tb/tb_conv_21_acc_sat.sv
// Scoreboard bench for conv_21_acc_sat: directed windows push expected results, a monitor checks handshakes.
module tb_conv_21_acc_sat;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [23:0] prod_din;
  logic        prod_valid;
  logic        prod_ready;
  logic [31:0] bias;
  logic [15:0] out_dout;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  logic signed [15:0] exp_q[$];

`ifdef CONV_21_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  conv_21_acc_sat #(
    .PROD_WIDTH(24), .ACC_WIDTH(32), .TAPS(9), .SHIFT(8), .OUT_WIDTH(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_din(prod_din), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .bias(bias), .out_dout(out_dout), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic signed [15:0] rl(input logic signed [15:0] v);
    return (RELU && v < 0) ? 16'sd0 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Output monitor: every handshake pops and compares one expected result.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(out_dout));
      end else begin
        logic signed [15:0] e;
        e = exp_q.pop_front();
        if ($signed(out_dout) !== e) begin
          failures++;
          $display("FAIL result: got %0d expected %0d", $signed(out_dout), e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] b, input logic [23:0] p);
    int unsigned n;
    n = 0;
    bias = b; prod_din = p; prod_valid = 1'b1;
    @(negedge ap_clk);
    while (prod_ready !== 1'b1 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (prod_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got prod_ready=%b expected 1", prod_ready);
    end
    @(posedge ap_clk); #1;
    prod_valid = 1'b0; prod_din = $urandom; bias = $urandom;
  endtask

  task automatic window(input logic [31:0] b, input logic [23:0] p, input int gap);
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? b : $urandom, p);
      repeat (gap) begin @(posedge ap_clk); #1; end
    end
  endtask

  initial begin
    ap_rst = 1'b1; out_ready = 1'b1; prod_valid = 1'b0; prod_din = '0; bias = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_prod_ready", prod_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dout", out_dout, 0);
    // Products offered during reset must be ignored.
    prod_valid = 1'b1; prod_din = 24'h7FFFFF; bias = 32'h7FFF_0000;
    @(posedge ap_clk); #1;
    prod_valid = 1'b0; ap_rst = 1'b0;

    // Basic window with latency check.
    exp_q.push_back(16'sd9);
    window(0, 24'd256, 0);
    check("basic_valid_latency", out_valid, 1);

    // Rounding around the half point, with stalls between taps.
    exp_q.push_back(16'sd1);   window(128, 24'd0, 2);
    exp_q.push_back(16'sd0);   window(127, 24'd0, 0);
    exp_q.push_back(rl(-16'sd1)); window(-129, 24'd0, 1);
    exp_q.push_back(16'sd0);   window(-128, 24'd0, 0);
    exp_q.push_back(rl(-16'sd9)); window(-5000, 24'd300, 0);

    // Saturation both ways.
    exp_q.push_back(16'sd32767);       window(0, 24'h7FFFFF, 0);
    exp_q.push_back(rl(-16'sd32768));  window(0, 24'h800000, 0);

    // Backpressure: result held, no product consumed, then same-cycle handshake and tap 0.
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    exp_q.push_back(16'sd18);
    window(0, 24'd512, 0);
    check("bp_valid", out_valid, 1);
    prod_valid = 1'b1; prod_din = 24'd256; bias = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_dout", out_dout, 18);
      check("bp_prod_ready", prod_ready, 0);
    end
    @(posedge ap_clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(16'sd9);
    @(negedge ap_clk);
    check("bp_release_ready", prod_ready, 1);
    @(posedge ap_clk); #1;
    check("bp_valid_cleared", out_valid, 0);
    prod_valid = 1'b0;
    for (int i = 0; i < 8; i++) send($urandom, 24'd256);

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 4; i++) send((i == 0) ? 32'd5000 : $urandom, 24'd1000);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    exp_q.push_back(16'sd9);
    window(0, 24'd256, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge ap_clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
